// File: rtl/vga_timing_640_480.sv
// rtl/vga_timing_640_480.sv - 640x480 VGA scan counters, syncs, pixel indices and frame pulse
module vga_timing_640_480 #(
   parameter int   H_VISIBLE   = 640,
   parameter int   H_FP        = 16,
   parameter int   H_SYNC      = 96,
   parameter int   H_BP        = 48,
   parameter int   V_VISIBLE   = 480,
   parameter int   V_FP        = 10,
   parameter int   V_SYNC      = 2,
   parameter int   V_BP        = 33,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic       clk,
   input  logic       i_sclr,
   input  logic       i_px_clk,
   output logic       o_hsync,
   output logic       o_vsync,
   output logic       o_haddr_enb,
   output logic       o_vaddr_enb,
   output logic [9:0] o_hidx,
   output logic [8:0] o_vidx,
   output logic       o_frame_en
);

   localparam logic [9:0] H_TOTAL  = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP);
   localparam logic [9:0] V_TOTAL  = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

   logic [9:0] r_hcnt;
   logic [9:0] r_vcnt;
   logic       r_frame_en;

   logic w_h_last;
   logic w_v_last;
   logic w_haddr_enb;
   logic w_vaddr_enb;
   logic w_hsync_act;
   logic w_vsync_act;

   assign w_h_last = (r_hcnt == H_TOTAL - 10'd1);
   assign w_v_last = (r_vcnt == V_TOTAL - 10'd1);

   // Line and frame wrap share one edge so (0,V_TOTAL-1) is never observed.
   always_ff @(posedge clk) begin
      if (i_sclr) begin
         r_hcnt     <= '0;
         r_vcnt     <= '0;
         r_frame_en <= 1'b0;
      end else begin
         r_frame_en <= i_px_clk & w_h_last & w_v_last;
         if (i_px_clk) begin
            if (w_h_last) begin
               r_hcnt <= '0;
               r_vcnt <= w_v_last ? 10'd0 : r_vcnt + 10'd1;
            end else begin
               r_hcnt <= r_hcnt + 10'd1;
            end
         end
      end
   end

   assign w_haddr_enb = (r_hcnt < H_VIS);
   assign w_vaddr_enb = (r_vcnt < V_VIS);
   assign w_hsync_act = (r_hcnt >= HS_START) && (r_hcnt < HS_END);
   assign w_vsync_act = (r_vcnt >= VS_START) && (r_vcnt < VS_END);

   assign o_haddr_enb = w_haddr_enb;
   assign o_vaddr_enb = w_vaddr_enb;
   assign o_hidx      = w_haddr_enb ? r_hcnt : 10'd0;
   assign o_vidx      = w_vaddr_enb ? r_vcnt[8:0] : 9'd0;
   assign o_hsync     = w_hsync_act ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   assign o_vsync     = w_vsync_act ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   assign o_frame_en  = r_frame_en;

endmodule

// File: tb/tb_vga_timing_640_480.sv
// tb/tb_vga_timing_640_480.sv - scoreboard bench: full-size line/stall checks, reduced-size frame checks
module tb_vga_timing_640_480;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       b_sclr = 1'b1, b_px = 1'b0;
   logic       b_hs, b_vs, b_ha, b_va, b_fr;
   logic [9:0] b_hidx;
   logic [8:0] b_vidx;
   logic       s_sclr = 1'b1, s_px = 1'b0;
   logic       s_hs, s_vs, s_ha, s_va, s_fr;
   logic [9:0] s_hidx;
   logic [8:0] s_vidx;

   vga_timing_640_480 u_big (
      .clk(clk), .i_sclr(b_sclr), .i_px_clk(b_px),
      .o_hsync(b_hs), .o_vsync(b_vs), .o_haddr_enb(b_ha), .o_vaddr_enb(b_va),
      .o_hidx(b_hidx), .o_vidx(b_vidx), .o_frame_en(b_fr)
   );

   // Reduced frame: H 8+2+3+3=16, V 4+1+2+1=8, active-high syncs.
   vga_timing_640_480 #(
      .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_ACTIVE(1'b1)
   ) u_small (
      .clk(clk), .i_sclr(s_sclr), .i_px_clk(s_px),
      .o_hsync(s_hs), .o_vsync(s_vs), .o_haddr_enb(s_ha), .o_vaddr_enb(s_va),
      .o_hidx(s_hidx), .o_vidx(s_vidx), .o_frame_en(s_fr)
   );

   typedef struct packed {
      logic        sel;
      logic [23:0] v;
   } rec_t;

   rec_t q[$];
   int   n_vec  = 0;
   int   n_fail = 0;
   int   bh = 0, bv = 0, sh = 0, sv = 0;
   logic bfr = 1'b0, sfr = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [23:0] exp_big(input int h, input int v, input logic fr);
      logic ha, va, hs, vs;
      logic [9:0] hi;
      logic [8:0] vi;
      ha = (h < 640);
      va = (v < 480);
      hs = !(h >= 656 && h < 752);
      vs = !(v >= 490 && v < 492);
      hi = ha ? 10'(h) : 10'd0;
      vi = va ? 9'(v) : 9'd0;
      return {fr, hs, vs, ha, va, hi, vi};
   endfunction

   function automatic logic [23:0] exp_small(input int h, input int v, input logic fr);
      logic ha, va, hs, vs;
      logic [9:0] hi;
      logic [8:0] vi;
      ha = (h < 8);
      va = (v < 4);
      hs = (h >= 10 && h < 13);
      vs = (v >= 5 && v < 7);
      hi = ha ? 10'(h) : 10'd0;
      vi = va ? 9'(v) : 9'd0;
      return {fr, hs, vs, ha, va, hi, vi};
   endfunction

   task automatic step_big(input logic sclr, input logic px);
      rec_t r;
      @(negedge clk);
      b_sclr = sclr;
      b_px   = px;
      if (sclr) begin
         bh = 0; bv = 0; bfr = 1'b0;
      end else begin
         bfr = px && bh == 799 && bv == 524;
         if (px) begin
            if (bh == 799) begin bh = 0; bv = (bv == 524) ? 0 : bv + 1; end
            else bh = bh + 1;
         end
      end
      r.sel = 1'b0;
      r.v   = exp_big(bh, bv, bfr);
      q.push_back(r);
   endtask

   task automatic step_small(input logic sclr, input logic px);
      rec_t r;
      @(negedge clk);
      s_sclr = sclr;
      s_px   = px;
      if (sclr) begin
         sh = 0; sv = 0; sfr = 1'b0;
      end else begin
         sfr = px && sh == 15 && sv == 7;
         if (px) begin
            if (sh == 15) begin sh = 0; sv = (sv == 7) ? 0 : sv + 1; end
            else sh = sh + 1;
         end
      end
      r.sel = 1'b1;
      r.v   = exp_small(sh, sv, sfr);
      q.push_back(r);
   endtask

   // Idle clocks then one enable; returns with outputs of the enabled state settled.
   task automatic en_big(input int gap);
      repeat (gap) step_big(1'b0, 1'b0);
      step_big(1'b0, 1'b1);
      @(posedge clk);
      #2;
   endtask

   task automatic en_small(input int gap);
      repeat (gap) step_small(1'b0, 1'b0);
      step_small(1'b0, 1'b1);
      @(posedge clk);
      #2;
   endtask

   initial begin : monitor
      rec_t e;
      logic [23:0] act;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e   = q.pop_front();
            act = e.sel ? {s_fr, s_hs, s_vs, s_ha, s_va, s_hidx, s_vidx}
                        : {b_fr, b_hs, b_vs, b_ha, b_va, b_hidx, b_vidx};
            check(e.sel ? "small_outputs" : "big_outputs", 32'(act), 32'(e.v));
         end
      end
   end

   initial begin : stimulus
      int cnt_ha, cnt_hs, first_hs, cnt_vs, cnt_va_lo, n_fr, first_fr, last_fr, gap_fr;

      // Full-size reset with enables held high.
      repeat (3) step_big(1'b1, 1'b1);
      @(posedge clk); #2;
      check("big_reset_hsync", 32'(b_hs), 32'd1);
      check("big_reset_frame", 32'(b_fr), 32'd0);

      // One line plus one pixel at every 4th clk.
      cnt_ha = 0; cnt_hs = 0; first_hs = -1;
      for (int k = 1; k <= 800; k++) begin
         en_big(3);
         if (b_ha) cnt_ha++;
         if (!b_hs) begin
            cnt_hs++;
            if (first_hs < 0) first_hs = k;
         end
         if (k == 639) check("hidx_last_visible", 32'(b_hidx), 32'd639);
         if (k == 640) check("hidx_after_visible", 32'(b_hidx), 32'd0);
         if (k == 799) check("vidx_before_wrap", 32'(b_vidx), 32'd0);
         if (k == 800) check("vidx_after_wrap", 32'(b_vidx), 32'd1);
      end
      check("haddr_enable_count", 32'(cnt_ha), 32'd640);
      check("hsync_low_count", 32'(cnt_hs), 32'd96);
      check("hsync_first_low", 32'(first_hs), 32'd656);

      // Advance to hcnt=655 on line 1, stall 50 clks, then one enable into hsync.
      repeat (655) en_big(0);
      step_big(1'b0, 1'b0);
      repeat (49) step_big(1'b0, 1'b0);
      @(posedge clk); #2;
      check("stall_hsync_idle", 32'(b_hs), 32'd1);
      en_big(0);
      check("stall_release_hsync", 32'(b_hs), 32'd0);
      step_big(1'b0, 1'b0);

      // Reduced-size frame checks.
      repeat (3) step_small(1'b1, 1'b1);
      cnt_vs = 0; cnt_va_lo = 0; n_fr = 0; first_fr = -1;
      for (int k = 1; k <= 128; k++) begin
         en_small(3);
         if (s_vs) cnt_vs++;
         if (!s_va) cnt_va_lo++;
         if (s_fr) begin
            n_fr++;
            if (first_fr < 0) first_fr = k;
         end
      end
      check("vsync_active_count", 32'(cnt_vs), 32'd32);
      check("vaddr_low_count", 32'(cnt_va_lo), 32'd64);
      check("frame_pulse_count", 32'(n_fr), 32'd1);
      check("frame_pulse_enable", 32'(first_fr), 32'd128);

      // Back-to-back enables for two frames.
      n_fr = 0; last_fr = -1; gap_fr = -1;
      for (int k = 1; k <= 256; k++) begin
         en_small(0);
         if (s_fr) begin
            n_fr++;
            if (last_fr >= 0) gap_fr = k - last_fr;
            last_fr = k;
         end
      end
      check("b2b_pulse_count", 32'(n_fr), 32'd2);
      check("b2b_pulse_spacing", 32'(gap_fr), 32'd128);

      // Mid-frame reset inside both sync pulses.
      repeat (107) en_small(0);
      check("pre_reset_hsync", 32'(s_hs), 32'd1);
      check("pre_reset_vsync", 32'(s_vs), 32'd1);
      step_small(1'b1, 1'b1);
      @(posedge clk); #2;
      check("post_reset_hidx", 32'(s_hidx), 32'd0);
      check("post_reset_frame", 32'(s_fr), 32'd0);
      first_fr = -1;
      for (int k = 1; k <= 128; k++) begin
         en_small(0);
         if (s_fr && first_fr < 0) first_fr = k;
      end
      check("post_reset_first_frame", 32'(first_fr), 32'd128);
      step_small(1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #3;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_timing_640_480.md
# vga_timing_640_480

Timing generator for the 640x480 VGA output path. It runs the horizontal and vertical scan counters and produces hsync and vsync. It also drives the visible-area enables, the pixel indices and the per-frame pulse that feed the downstream pixel/pattern generator. It advances only on the pixel-clock enable, so the whole path runs in the single system clock domain.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE, 1'b0, level of hsync/vsync during the sync pulse

Ports:
- clk  input  1  system clock; the only clock
- i_sclr  input  1  reset, synchronous, active-high
- i_px_clk  input  1  pixel-clock enable, one clk wide, nominally every 4th clk
- o_hsync  output  1  horizontal sync
- o_vsync  output  1  vertical sync
- o_haddr_enb  output  1  horizontal counter is in the visible region
- o_vaddr_enb  output  1  vertical counter is in the visible region
- o_hidx  output  10  pixel column 0..639; 0 outside the visible region
- o_vidx  output  9  pixel row 0..479; 0 outside the visible region
- o_frame_en  output  1  one-clk pulse at the start of each frame

## Operation
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP = 800.
- V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP = 525.
- Internal registers:
  - hcnt[9:0], range 0..H_TOTAL-1
  - vcnt[9:0], range 0..V_TOTAL-1
  - frame_en register
- On a clk edge with i_px_clk=1:
  - if hcnt==H_TOTAL-1: hcnt<=0, and vcnt advances (wraps to 0 when it equals V_TOTAL-1, else +1)
  - otherwise hcnt<=hcnt+1 and vcnt holds
- With i_px_clk=0 all counters hold.
- Decoded outputs are combinational from the registered counters, with no extra pipeline stage:
  - o_haddr_enb = (hcnt < H_VISIBLE)
  - o_vaddr_enb = (vcnt < V_VISIBLE)
  - o_hidx = o_haddr_enb ? hcnt : 0
  - o_vidx = o_vaddr_enb ? vcnt[8:0] : 0
  - o_hsync = SYNC_ACTIVE when H_VISIBLE+H_FP <= hcnt < H_VISIBLE+H_FP+H_SYNC (656..751), else ~SYNC_ACTIVE
  - o_vsync = SYNC_ACTIVE when V_VISIBLE+V_FP <= vcnt < V_VISIBLE+V_FP+V_SYNC (490..491), else ~SYNC_ACTIVE
- o_frame_en is registered. It is set for exactly one clk when the previous edge had i_px_clk=1, hcnt==799 and vcnt==524. It is therefore high in the same clk that the counters first read (0,0).
- Exactly one o_frame_en pulse per V_TOTAL*H_TOTAL = 420000 pixel enables.
- Width rules:
  - counter compares are 10-bit unsigned
  - vcnt is truncated to 9 bits only after the visible check
- Reset (i_sclr=1) has priority over i_px_clk:
  - hcnt=0, vcnt=0, frame_en=0
  - hence o_haddr_enb=1, o_vaddr_enb=1, o_hidx=0, o_vidx=0
  - o_hsync=o_vsync=~SYNC_ACTIVE, o_frame_en=0
- Reset mid-frame returns to (0,0) on that edge. No o_frame_en is generated by the reset.
- After reset, the first o_frame_en comes after a full 420000 enables, not immediately.

## Timing
- Counter update to decoded-output latency: 0 clk (same cycle as the counter register).
- Pixel (hidx, vidx) is presented for one full pixel period, i.e. from one i_px_clk edge until the next.
- hsync has the same alignment as hidx.
- o_frame_en:
  - asserted 1 clk after the final pixel-enable edge of a frame
  - deasserted the following clk, regardless of i_px_clk
- Line and frame wrap (hcnt 799->0 and vcnt 524->0) occur on the same clk edge. There is no intermediate state where hcnt=0 and vcnt=524.
- i_px_clk held high every clk is legal: one pixel per clk, same sequence.

## Test plan
- Reset then idle: assert i_sclr 3 clks with i_px_clk=1 -> counters stay 0; o_hsync=o_vsync=1; o_haddr_enb=o_vaddr_enb=1; o_frame_en=0 throughout.
- One line, i_px_clk every 4th clk:
  - o_haddr_enb high for exactly 640 enables
  - o_hidx runs 0..639 then reads 0
  - o_hsync low for exactly 96 enables beginning at hcnt=656
  - o_vidx increments 0->1 at enable #800
- Full frame:
  - o_vsync low for exactly 1600 enables, covering lines 490-491
  - o_vaddr_enb low for lines 480-524
  - o_frame_en pulses once, one clk wide, after enable #420000, with counters reading (0,0) that cycle
- Stall: hold i_px_clk=0 for 50 clks at hcnt=655 -> all outputs frozen; the next enable moves hcnt to 656 and o_hsync goes low.
- Reset mid-frame at hcnt=700, vcnt=491:
  - next clk: counters (0,0), o_hsync=o_vsync=1, no o_frame_en
  - the next o_frame_en arrives after 420000 enables
- Back-to-back: i_px_clk=1 every clk for 2 frames -> o_frame_en exactly 420000 clks apart; no sync glitches at the wrap.
